regfile_param: RTL and testbench

Parametrised register file for the CPU datapath, the successor to the fixed 16×24-bit register array. Width, depth, per-register reset values and read-only registers are set by parameters. It adds an optional write-to-read bypass, a single debug snoop port in place of the per-register outputs, and a clear sequencer that restores every register to its reset value on request. It sits between the controller's write-back path and the ALU operand inputs.

---
 rtl/regfile_pkg.sv | 33 +++
 rtl/regfile_if.sv | 32 +++
 rtl/regfile_clr_seq.sv | 100 ++++++++++
 rtl/regfile_param.sv | 128 ++++++++++++
 tb/tb_regfile_param.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file: clear-FSM state
// encoding, parameter limits and the reset-value slicing helper.
package regfile_pkg;

    // Upper bounds used by the reset-value helper; DATA_W and DEPTH must not exceed them.
    localparam int MAX_W      = 64;
    localparam int MAX_DEPTH  = 256;
    localparam int MAX_INIT_W = MAX_W * MAX_DEPTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

    // Extract the reset/clear value of register idx from a flattened INIT vector
    // (zero-extended to MAX_INIT_W). Result is zero-extended to MAX_W bits.
    function automatic logic [MAX_W-1:0] init_slice(input logic [MAX_INIT_W-1:0] init_vec,
                                                    input int idx,
                                                    input int data_w);
        logic [MAX_W-1:0] res;
        res = {MAX_W{1'b0}};
        for (int b = 0; b < MAX_W; b++) begin
            if (b < data_w) begin
                res[b] = init_vec[idx * data_w + b];
            end else begin
                res[b] = 1'b0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_if.sv
// Bus bundle for the register file: write port, two read ports, clear
// handshake and debug snoop port. The master drives requests, the slave is the
// register file.
interface regfile_if #(
    parameter int DATA_W = 24,
    parameter int AW     = 4
);
    logic              we;
    logic [AW-1:0]     dst;
    logic [DATA_W-1:0] data;
    logic              wr_ready;
    logic              wr_err;
    logic [AW-1:0]     src0;
    logic [AW-1:0]     src1;
    logic [DATA_W-1:0] outa;
    logic [DATA_W-1:0] outb;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;
    logic [AW-1:0]     dbg_sel;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output we, dst, data, src0, src1, clr_req, dbg_sel,
        input  wr_ready, wr_err, outa, outb, clr_busy, clr_done, dbg_data
    );

    modport slave (
        input  we, dst, data, src0, src1, clr_req, dbg_sel,
        output wr_ready, wr_err, outa, outb, clr_busy, clr_done, dbg_data
    );
endinterface

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: on request, walks a pointer over every register address so
// the array can reload its reset values, then signals completion for one cycle.
import regfile_pkg::*;

module regfile_clr_seq #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          wr_ready,
    output logic          sweep_en,
    output logic [AW-1:0] sweep_addr
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    clr_state_e    state_r;
    clr_state_e    state_nxt_s;
    logic [AW-1:0] ptr_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; requests outside IDLE are ignored
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (clr_req) begin
                    state_nxt_s = SWEEP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SWEEP: begin
                if (ptr_r == LAST_ADDR) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SWEEP;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Sweep pointer: loaded with 0 on request, advances once per SWEEP cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {AW{1'b0}};
        end else if (state_r == SWEEP) begin
            if (ptr_r == LAST_ADDR) begin
                ptr_r <= {AW{1'b0}};
            end else begin
                ptr_r <= ptr_r + AW'(1);
            end
        end else if ((state_r == IDLE) && clr_req) begin
            ptr_r <= {AW{1'b0}};
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Outputs decoded directly from the state register
    always_comb begin
        clr_busy   = 1'b0;
        clr_done   = 1'b0;
        wr_ready   = 1'b1;
        sweep_en   = 1'b0;
        sweep_addr = ptr_r;
        case (state_r)
            IDLE: begin
                wr_ready = 1'b1;
            end
            SWEEP: begin
                clr_busy = 1'b1;
                wr_ready = 1'b0;
                sweep_en = 1'b1;
            end
            DONE: begin
                clr_done = 1'b1;
                wr_ready = 1'b1;
            end
            default: begin
                wr_ready = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: storage array with reset values, write-reject
// for read-only or out-of-range addresses, optional write-to-read bypass on
// the two operand ports, an unbypassed debug port and a clear sequencer.
import regfile_pkg::*;

module regfile_param #(
    parameter int                      DATA_W  = 24,
    parameter int                      DEPTH   = 16,
    parameter int                      AW      = $clog2(DEPTH),
    parameter logic [DATA_W*DEPTH-1:0] INIT    = '0,
    parameter logic [DEPTH-1:0]        RO_MASK = '0,
    parameter bit                      BYPASS  = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    regfile_if.slave bus
);

    localparam logic [MAX_INIT_W-1:0] INIT_EXT = MAX_INIT_W'(INIT);
    localparam logic [31:0]           DEPTH_U  = 32'(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              wr_err_r;
    logic              wr_ready_s;
    logic              sweep_en_s;
    logic [AW-1:0]     sweep_addr_s;
    logic              ro_hit_s;
    logic              reject_s;
    logic              wr_ok_s;
    logic [DATA_W-1:0] outa_s;
    logic [DATA_W-1:0] outb_s;
    logic [DATA_W-1:0] dbg_s;

    regfile_clr_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req    (bus.clr_req),
        .clr_busy   (bus.clr_busy),
        .clr_done   (bus.clr_done),
        .wr_ready   (wr_ready_s),
        .sweep_en   (sweep_en_s),
        .sweep_addr (sweep_addr_s)
    );

    // Write qualification: accepted writes to read-only or unmapped addresses are rejected
    always_comb begin
        ro_hit_s = 1'b0;
        if (32'(bus.dst) < DEPTH_U) begin
            ro_hit_s = RO_MASK[bus.dst];
        end else begin
            ro_hit_s = 1'b1;
        end
        reject_s = bus.we && wr_ready_s && ro_hit_s;
        wr_ok_s  = bus.we && wr_ready_s && !ro_hit_s;
    end

    // Storage array: reset/sweep reload INIT values, otherwise accepted writes update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= DATA_W'(init_slice(INIT_EXT, i, DATA_W));
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sweep_en_s && (sweep_addr_s == AW'(i))) begin
                    mem_r[i] <= DATA_W'(init_slice(INIT_EXT, i, DATA_W));
                end else if (wr_ok_s && (bus.dst == AW'(i))) begin
                    mem_r[i] <= bus.data;
                end else begin
                    mem_r[i] <= mem_r[i];
                end
            end
        end
    end

    // Rejected-write flag, high for the cycle after the offending edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_r <= 1'b0;
        end else begin
            wr_err_r <= reject_s;
        end
    end

    // Operand read port A with optional forwarding of the in-flight write
    always_comb begin
        outa_s = {DATA_W{1'b0}};
        if (BYPASS && wr_ok_s && (bus.src0 == bus.dst)) begin
            outa_s = bus.data;
        end else if (32'(bus.src0) < DEPTH_U) begin
            outa_s = mem_r[bus.src0];
        end else begin
            outa_s = {DATA_W{1'b0}};
        end
    end

    // Operand read port B with optional forwarding of the in-flight write
    always_comb begin
        outb_s = {DATA_W{1'b0}};
        if (BYPASS && wr_ok_s && (bus.src1 == bus.dst)) begin
            outb_s = bus.data;
        end else if (32'(bus.src1) < DEPTH_U) begin
            outb_s = mem_r[bus.src1];
        end else begin
            outb_s = {DATA_W{1'b0}};
        end
    end

    // Debug snoop port: stored contents only, never forwarded
    always_comb begin
        dbg_s = {DATA_W{1'b0}};
        if (32'(bus.dbg_sel) < DEPTH_U) begin
            dbg_s = mem_r[bus.dbg_sel];
        end else begin
            dbg_s = {DATA_W{1'b0}};
        end
    end

    assign bus.wr_ready = wr_ready_s;
    assign bus.wr_err   = wr_err_r;
    assign bus.outa     = outa_s;
    assign bus.outb     = outb_s;
    assign bus.dbg_data = dbg_s;

endmodule

// File: tb/tb_regfile_param.sv
// Directed testbench for regfile_param: reset values, bypass, read-only
// reject, clear sweep, write racing a clear request, and reset mid-sweep.
module tb_regfile_param;

    localparam int DATA_W = 24;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam logic [DATA_W*DEPTH-1:0] INIT_V =
        {{(14*DATA_W){1'b0}}, 24'h420003, 24'h840204};

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   n;

    regfile_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

    regfile_param #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .AW      (AW),
        .INIT    (INIT_V),
        .RO_MASK (16'h1000),
        .BYPASS  (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b1;
        bus.we      = 1'b0;
        bus.dst     = 4'd0;
        bus.data    = 24'h0;
        bus.src0    = 4'd0;
        bus.src1    = 4'd0;
        bus.clr_req = 1'b0;
        bus.dbg_sel = 4'd0;

        // Reset pulse in the middle of a cycle
        #2 rst_n = 1'b0;
        #1 chk("rst_dbg0", 32'(bus.dbg_data), 32'h00840204);
        bus.dbg_sel = 4'd1;
        #1 chk("rst_dbg1", 32'(bus.dbg_data), 32'h00420003);
        bus.dbg_sel = 4'd5;
        #1 chk("rst_dbg5", 32'(bus.dbg_data), 32'h00000000);
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("rst_wr_err",   32'(bus.wr_err),   32'd0);
        chk("rst_busy",     32'(bus.clr_busy), 32'd0);
        chk("rst_done",     32'(bus.clr_done), 32'd0);
        #3 rst_n = 1'b1;

        // Write with bypass to register 3
        tick();
        bus.we = 1'b1; bus.dst = 4'd3; bus.data = 24'hABCDEF;
        bus.src0 = 4'd3; bus.src1 = 4'd4; bus.dbg_sel = 4'd3;
        #1 chk("byp_outa", 32'(bus.outa), 32'h00ABCDEF);
        chk("byp_outb", 32'(bus.outb), 32'h00000000);
        chk("byp_dbg_nobypass", 32'(bus.dbg_data), 32'h00000000);
        tick();
        bus.we = 1'b0;
        #1 chk("wr_dbg3", 32'(bus.dbg_data), 32'h00ABCDEF);
        chk("wr_outa_stored", 32'(bus.outa), 32'h00ABCDEF);
        chk("wr_no_err", 32'(bus.wr_err), 32'd0);

        // Read-only register 12 rejects the write, no forwarding
        bus.we = 1'b1; bus.dst = 4'd12; bus.data = 24'h123456;
        bus.src0 = 4'd12; bus.dbg_sel = 4'd12;
        #1 chk("ro_outa_nobypass", 32'(bus.outa), 32'h00000000);
        tick();
        bus.we = 1'b0;
        #1 chk("ro_err_pulse", 32'(bus.wr_err), 32'd1);
        chk("ro_dbg12", 32'(bus.dbg_data), 32'h00000000);
        tick();
        chk("ro_err_clear", 32'(bus.wr_err), 32'd0);

        // Clear sweep after overwriting register 0
        bus.we = 1'b1; bus.dst = 4'd0; bus.data = 24'h111111; bus.dbg_sel = 4'd0;
        tick();
        bus.we = 1'b0;
        #1 chk("clr_pre_dbg0", 32'(bus.dbg_data), 32'h00111111);
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        chk("clr_busy_first", 32'(bus.clr_busy), 32'd1);
        chk("clr_wr_ready_low", 32'(bus.wr_ready), 32'd0);
        bus.we = 1'b1; bus.dst = 4'd2; bus.data = 24'h777777; bus.src0 = 4'd2;
        #1 chk("clr_busy_nobypass", 32'(bus.outa), 32'h00000000);
        n = 1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (k == 0) begin
                chk("clr_drop_no_err", 32'(bus.wr_err), 32'd0);
                bus.we = 1'b0;
            end
            if (bus.clr_busy) begin
                n++;
            end else begin
                break;
            end
        end
        chk("clr_busy_cycles", 32'(n), 32'd16);
        chk("clr_done_pulse", 32'(bus.clr_done), 32'd1);
        chk("clr_done_ready", 32'(bus.wr_ready), 32'd1);
        #1 chk("clr_dbg0", 32'(bus.dbg_data), 32'h00840204);
        bus.dbg_sel = 4'd2;
        #1 chk("clr_dbg2_dropped", 32'(bus.dbg_data), 32'h00000000);
        bus.dbg_sel = 4'd3;
        #1 chk("clr_dbg3", 32'(bus.dbg_data), 32'h00000000);
        tick();
        chk("clr_done_one_cycle", 32'(bus.clr_done), 32'd0);

        // Write and clear request in the same IDLE cycle
        bus.we = 1'b1; bus.dst = 4'd5; bus.data = 24'h5A5A5A;
        bus.clr_req = 1'b1; bus.dbg_sel = 4'd5;
        tick();
        bus.we = 1'b0; bus.clr_req = 1'b0;
        #1 chk("sim_dbg5_commit", 32'(bus.dbg_data), 32'h005A5A5A);
        chk("sim_busy", 32'(bus.clr_busy), 32'd1);
        n = 1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.clr_busy) begin
                n++;
            end else begin
                break;
            end
        end
        chk("sim_busy_cycles", 32'(n), 32'd16);
        chk("sim_done", 32'(bus.clr_done), 32'd1);
        chk("sim_dbg5_cleared", 32'(bus.dbg_data), 32'h00000000);

        // Reset during the seventh sweep cycle
        tick();
        bus.we = 1'b1; bus.dst = 4'd10; bus.data = 24'hBEEF01;
        tick();
        bus.dst = 4'd1; bus.data = 24'h222222;
        tick();
        bus.we = 1'b0; bus.dbg_sel = 4'd10;
        #1 chk("mid_pre_dbg10", 32'(bus.dbg_data), 32'h00BEEF01);
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        repeat (6) tick();
        chk("mid_busy_cycle7", 32'(bus.clr_busy), 32'd1);
        rst_n = 1'b0;
        #1 chk("mid_busy_low", 32'(bus.clr_busy), 32'd0);
        chk("mid_no_done", 32'(bus.clr_done), 32'd0);
        chk("mid_wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("mid_dbg10", 32'(bus.dbg_data), 32'h00000000);
        bus.dbg_sel = 4'd1;
        #1 chk("mid_dbg1", 32'(bus.dbg_data), 32'h00420003);
        bus.dbg_sel = 4'd0;
        #1 chk("mid_dbg0", 32'(bus.dbg_data), 32'h00840204);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.clr_done || bus.clr_busy) begin
                chk("mid_post_idle", {30'd0, bus.clr_busy, bus.clr_done}, 32'd0);
                break;
            end
        end
        chk("mid_post_done", 32'(bus.clr_done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
